// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : serial_adder_pkg
//  Purpose : Shared definitions for the bit-serial adder controller:
//            FSM state encodings and the bit-counter width helper.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must index WIDTH bit positions. A 1-bit counter is the
    // floor so the WIDTH=1 build still has a legal vector.
    function automatic int cnt_width(input int w);
        if (w <= 1) begin
            return 1;
        end
        return $clog2(w);
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_ctrl_fa.sv
`default_nettype none
// ============================================================================
//  Module  : FullAdderCell
//  Purpose : Single-bit full adder, the only arithmetic resource of the
//            serial adder datapath.
//  Ports   : i_a, i_b, i_ci  - addend bits and carry-in
//            o_s, o_co       - sum bit and carry-out
//  Revision: 1.0 - initial release
// ============================================================================
module FullAdderCell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule : FullAdderCell
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : serial_adder_ctrl
//  Purpose : Bit-serial adder. Adds two WIDTH-bit operands LSB first, one
//            bit per clock, through a single full adder cell. Operands are
//            taken over a valid/ready handshake and the result is offered
//            over a second valid/ready handshake.
//  Ports   : clk, rst_n             - clock, async active-low reset
//            i_in_valid/o_in_ready  - operand handshake
//            i_a, i_b, i_cin        - operands, sampled on accept
//            i_sub                  - subtract select (SERIAL_ADDER_SUB_EN)
//            o_out_valid/i_out_ready- result handshake
//            o_sum, o_cout          - registered result
//  Macro   : SERIAL_ADDER_SUB_EN - adds i_sub; sum = a - b when set,
//            cout=1 meaning no borrow, cin ignored.
//  Revision: 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int                c_CNT_W    = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_fa_sum;
    logic               w_fa_co;
    logic [WIDTH-1:0]   w_sum_shift;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;

    // Subtraction is a + ~b + 1: invert b on load and force the carry.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = i_sub ? ~i_b : i_b;
    assign w_c_load = i_sub ? 1'b1 : i_cin;
`else
    assign w_b_load = i_b;
    assign w_c_load = i_cin;
`endif

    FullAdderCell u_fa (
        .i_a  (r_a_sh[0]),
        .i_b  (r_b_sh[0]),
        .i_ci (r_carry),
        .o_s  (w_fa_sum),
        .o_co (w_fa_co)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts the LSB
    // computed first lands in bit 0.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_shift = w_fa_sum;
        end else begin : g_sum_wn
            assign w_sum_shift = {w_fa_sum, r_sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_a_sh  <= i_a;
                        r_b_sh  <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_sum   <= w_sum_shift;
                    r_carry <= w_fa_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_cout  <= w_fa_co;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // rst_n gating keeps in_ready low for the whole reset interval even
    // though the state register already reads IDLE.
    assign o_in_ready  = rst_n && (r_state == ST_IDLE);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_sum       = r_sum;
    assign o_cout      = r_cout;

endmodule : serial_adder_ctrl
`default_nettype wire
